// File: rtl/lfsr_gen_if.sv
// Control and observation bundle for lfsr_gen: stepping/load controls in,
// register contents and status pulses out.
interface lfsr_gen_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEPS  = 1,
    parameter int unsigned PCNT_W = WIDTH + 1
);
    logic              en;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  state;
    logic [STEPS-1:0]  out_bits;
    logic              wrap;
    logic [PCNT_W-1:0] period_cnt;
    logic              lock_err;

    modport master (
        output en, load, load_val,
        input  state, out_bits, wrap, period_cnt, lock_err
    );

    modport slave (
        input  en, load, load_val,
        output state, out_bits, wrap, period_cnt, lock_err
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with multi-step advance, seed load with
// all-zero lockup protection, and a saturating period counter with wrap pulse.
module lfsr_gen #(
    parameter int unsigned      WIDTH  = 16,
    parameter int unsigned      MODE   = 0,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter logic [WIDTH-1:0] GPOLY  = 16'h6801,
    parameter logic [WIDTH-1:0] SEED   = '1,
    parameter int unsigned      STEPS  = 1,
    parameter int unsigned      PCNT_W = WIDTH + 1
) (
    input logic       clk,
    input logic       rst,
    lfsr_gen_if.slave bus
);

    logic [WIDTH-1:0]  state_q;
    logic [WIDTH-1:0]  start_q;
    logic [STEPS-1:0]  bits_q;
    logic              wrap_q;
    logic [PCNT_W-1:0] cnt_q;
    logic              lock_q;

    logic [WIDTH-1:0]  walk;
    logic [WIDTH-1:0]  adv_state;
    logic [STEPS-1:0]  adv_bits;

    // All STEPS single steps are chained in one cycle; bit 0 holds the first shifted-out bit.
    always_comb begin
        walk     = state_q;
        adv_bits = '0;
        for (int unsigned k = 0; k < STEPS; k++) begin
            adv_bits[k] = walk[WIDTH-1];
            if (MODE == 0)
                walk = {walk[WIDTH-2:0], ^(walk & TAPS)};
            else
                walk = {walk[WIDTH-2:0], 1'b0} ^ (walk[WIDTH-1] ? GPOLY : '0);
        end
        adv_state = walk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
            start_q <= SEED;
            bits_q  <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            lock_q <= 1'b0;
            if (bus.load) begin
                cnt_q  <= '0;
                bits_q <= '0;
                // A zero state would lock up the register, so fall back to SEED instead.
                if (bus.load_val == '0) begin
                    state_q <= SEED;
                    start_q <= SEED;
                    lock_q  <= 1'b1;
                end else begin
                    state_q <= bus.load_val;
                    start_q <= bus.load_val;
                end
            end else if (bus.en) begin
                state_q <= adv_state;
                bits_q  <= adv_bits;
                if (adv_state == start_q) begin
                    wrap_q <= 1'b1;
                    cnt_q  <= '0;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.out_bits   = bits_q;
    assign bus.wrap       = wrap_q;
    assign bus.period_cnt = cnt_q;
    assign bus.lock_err   = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: three configurations (4-bit Fibonacci, 16-bit Galois,
// 4-bit Fibonacci with 4 steps and a 2-bit counter) checked against a behavioural model.
module tb_lfsr_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(4),  .STEPS(1), .PCNT_W(5))  ifa ();
    lfsr_gen_if #(.WIDTH(16), .STEPS(1), .PCNT_W(17)) ifb ();
    lfsr_gen_if #(.WIDTH(4),  .STEPS(4), .PCNT_W(2))  ifc ();

    lfsr_gen #(.WIDTH(4), .MODE(0), .TAPS(4'hC), .GPOLY(4'h3), .SEED(4'hF),
               .STEPS(1), .PCNT_W(5)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    lfsr_gen #(.WIDTH(16), .MODE(1), .TAPS(16'hB400), .GPOLY(16'h6801), .SEED(16'hFFFF),
               .STEPS(1), .PCNT_W(17)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    lfsr_gen #(.WIDTH(4), .MODE(0), .TAPS(4'hC), .GPOLY(4'h3), .SEED(4'hF),
               .STEPS(4), .PCNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    // Model configuration, one entry per instance (a, b, c).
    int unsigned W    [3] = '{4, 16, 4};
    bit          MD   [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] MK   [3] = '{32'hC, 32'h6801, 32'hC};
    logic [31:0] SD   [3] = '{32'hF, 32'hFFFF, 32'hF};
    int unsigned ST   [3] = '{1, 1, 4};
    int unsigned CMAX [3] = '{31, 131071, 3};

    logic [31:0] ms [3];
    logic [31:0] mstart [3];
    logic [31:0] mob [3];
    int unsigned mcnt [3];
    bit          mwrap [3];
    bit          mlock [3];

    int nchecks = 0;
    int nerr    = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int i);
        return (32'h1 << W[i]) - 32'h1;
    endfunction

    function automatic logic [31:0] mstep(input int i, input logic [31:0] s, output bit ob);
        logic [31:0] m;
        m  = wmask(i);
        ob = s[W[i]-1];
        if (!MD[i]) return ((s << 1) | {31'b0, ^(s & MK[i])}) & m;
        else        return ((s << 1) & m) ^ (ob ? MK[i] : 32'h0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ms[i] = SD[i]; mstart[i] = SD[i]; mob[i] = '0;
            mcnt[i] = 0; mwrap[i] = 1'b0; mlock[i] = 1'b0;
        end
    endtask

    task automatic model_adv(input bit e, input bit l, input logic [31:0] v);
        bit b;
        for (int i = 0; i < 3; i++) begin
            mwrap[i] = 1'b0;
            mlock[i] = 1'b0;
            if (l) begin
                mcnt[i] = 0; mob[i] = '0;
                if ((v & wmask(i)) == 0) begin
                    ms[i] = SD[i]; mlock[i] = 1'b1;
                end else begin
                    ms[i] = v & wmask(i);
                end
                mstart[i] = ms[i];
            end else if (e) begin
                mob[i] = '0;
                for (int k = 0; k < int'(ST[i]); k++) begin
                    ms[i] = mstep(i, ms[i], b);
                    mob[i][k] = b;
                end
                if (ms[i] == mstart[i]) begin
                    mwrap[i] = 1'b1; mcnt[i] = 0;
                end else if (mcnt[i] < CMAX[i]) begin
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic tick(input bit e, input bit l, input logic [31:0] v);
        ifa.en = e; ifa.load = l; ifa.load_val = v[3:0];
        ifb.en = e; ifb.load = l; ifb.load_val = v[15:0];
        ifc.en = e; ifc.load = l; ifc.load_val = v[3:0];
        @(posedge clk);
        model_adv(e, l, v);
        #1;
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_state", 32'(ifa.state), ms[0]);
            check("a_bits",  32'(ifa.out_bits), mob[0]);
            check("a_wrap",  32'(ifa.wrap), 32'(mwrap[0]));
            check("a_cnt",   32'(ifa.period_cnt), mcnt[0]);
            check("a_lock",  32'(ifa.lock_err), 32'(mlock[0]));
            check("b_state", 32'(ifb.state), ms[1]);
            check("b_bits",  32'(ifb.out_bits), mob[1]);
            check("b_wrap",  32'(ifb.wrap), 32'(mwrap[1]));
            check("b_cnt",   32'(ifb.period_cnt), mcnt[1]);
            check("b_lock",  32'(ifb.lock_err), 32'(mlock[1]));
            check("c_state", 32'(ifc.state), ms[2]);
            check("c_bits",  32'(ifc.out_bits), mob[2]);
            check("c_wrap",  32'(ifc.wrap), 32'(mwrap[2]));
            check("c_cnt",   32'(ifc.period_cnt), mcnt[2]);
            check("c_lock",  32'(ifc.lock_err), 32'(mlock[2]));
        end
    end

    logic [3:0] seq [15] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                             4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

    initial begin
        rst = 1'b1;
        ifa.en = 0; ifa.load = 0; ifa.load_val = '0;
        ifb.en = 0; ifb.load = 0; ifb.load_val = '0;
        ifc.en = 0; ifc.load = 0; ifc.load_val = '0;
        model_reset();
        #2;
        check("rst_a_state", 32'(ifa.state), 32'hF);
        check("rst_b_state", 32'(ifb.state), 32'hFFFF);
        check("rst_a_cnt",   32'(ifa.period_cnt), 32'h0);
        check("rst_a_flags", {29'b0, ifa.wrap, ifa.lock_err, ifa.out_bits}, 32'h0);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // T1/T2/T3: free run from reset
        for (int k = 0; k < 15; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            check("t1_seq",  32'(ifa.state), 32'(seq[k]));
            check("t1_wrap", 32'(ifa.wrap), (k == 14) ? 32'h1 : 32'h0);
            check("t1_cnt",  32'(ifa.period_cnt), (k == 14) ? 32'h0 : 32'(k + 1));
            if (k == 0) begin
                check("t2_state", 32'(ifb.state), 32'h97FF);
                check("t2_bits",  32'(ifb.out_bits), 32'h1);
                check("t3_state1", 32'(ifc.state), 32'h1);
                check("t3_bits1",  32'(ifc.out_bits), 32'hF);
            end
            if (k == 1) begin
                check("t3_state2", 32'(ifc.state), 32'h3);
                check("t3_bits2",  32'(ifc.out_bits), 32'h8);
            end
            if (k == 4)  check("c_cnt_sat", 32'(ifc.period_cnt), 32'h3);
            if (k == 14) check("c_wrap15",  32'(ifc.wrap), 32'h1);
        end
        tick(1'b0, 1'b0, 32'h0);
        check("hold_state", 32'(ifa.state), 32'hF);
        check("hold_wrap",  32'(ifa.wrap), 32'h0);

        // T4: zero load rejected, then load 6 and run a full period
        tick(1'b1, 1'b1, 32'h0);
        check("t4_zero_state", 32'(ifa.state), 32'hF);
        check("t4_lock",       32'(ifa.lock_err), 32'h1);
        check("t4_cnt",        32'(ifa.period_cnt), 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("t4_lock_clr",   32'(ifa.lock_err), 32'h0);
        tick(1'b0, 1'b1, 32'h6);
        check("t4_load6", 32'(ifa.state), 32'h6);
        for (int k = 0; k < 15; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            check("t4_wrap", 32'(ifa.wrap), (k == 14) ? 32'h1 : 32'h0);
        end
        check("t4_back6", 32'(ifa.state), 32'h6);

        // T5: random enable gating
        repeat (40) tick(1'($urandom_range(0, 1)), 1'b0, 32'h0);

        // T6: asynchronous reset mid-cycle after 7 advances
        repeat (7) tick(1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_state", 32'(ifa.state), 32'hF);
        check("t6_bstate", 32'(ifb.state), 32'hFFFF);
        check("t6_cnt",   32'(ifa.period_cnt), 32'h0);
        check("t6_flags", {29'b0, ifa.wrap, ifa.lock_err, ifa.out_bits}, 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            check("t6_restart", 32'(ifa.state), 32'(seq[k]));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
